router_sched: RTL and testbench
===============================

ROUTER_SCHED -- requirements
Module: router_sched

Interface
REQ-001 Parameters: NPORT, default 8, number of input ports and of output ports; AW, default 4, destination address width.
REQ-002 clock  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_vld  input  NPORT  per input port: deserialized payload held and awaiting transfer.
REQ-005 req_addr  input  NPORT*AW  per input port destination; port i in bits [i*AW +: AW].
REQ-006 out_rdy  input  NPORT  per output port: ready to accept a new payload.
REQ-007 req_ack  output  NPORT  per input port, one-cycle pulse: payload taken or dropped.
REQ-008 out_load  output  NPORT  per output port, one-cycle pulse: load the payload selected by out_sel.
REQ-009 out_sel  output  NPORT*3  per output port: winning input index, valid while out_load is high.
REQ-010 err_drop  output  1  one-cycle pulse: a request with an out-of-range address was discarded.
REQ-011 drop_cnt  output  16  saturating count of discarded requests.

Function
REQ-012 Every output is registered; decisions from sampled inputs appear one cycle later.
REQ-013 Input i requests output o when req_vld[i]=1 and req_addr[i]==o with o<NPORT.
REQ-014 Each output o has an independent FSM with states IDLE and HOLD.
REQ-015 IDLE: if out_rdy[o]=1 and at least one input requests o, select a winner, go to HOLD, and in the next cycle assert out_load[o]=1, out_sel[o]=winner, req_ack[winner]=1.
REQ-016 IDLE with out_rdy[o]=0 or no request: stay in IDLE with all outputs 0.
REQ-017 HOLD lasts exactly one cycle, then returns to IDLE; out_rdy[o] is ignored in HOLD.
REQ-018 Winner selection is round-robin: the search starts at ptr[o]+1 modulo NPORT, and the first requesting index wins.
REQ-019 ptr[o] is updated to the winner only on a grant.
REQ-020 A requester keeps req_vld high until it sees req_ack, and drops it on the edge that ends the ack cycle.
REQ-021 Because of REQ-020 and the HOLD state, an acked request is never granted twice.
REQ-022 Each input targets one output, so at most one req_ack per input per cycle; grants to different outputs in the same cycle are independent and legal.
REQ-023 Requests with req_addr >= NPORT are discarded, lowest such index first, one per cycle.
REQ-024 A discard is reported next cycle with req_ack[i]=1 and err_drop=1; drop_cnt increments by 1 and saturates at 16'hFFFF.
REQ-025 A discard never asserts out_load.
REQ-026 Addresses are sampled only in the grant or drop decision cycle; changing req_addr while req_vld is high is illegal.

Reset
REQ-027 While reset=1, all FSMs are in IDLE.
REQ-028 While reset=1: ptr[o]=NPORT-1, so input 0 wins first; req_ack, out_load, out_sel, err_drop and drop_cnt are all 0.
REQ-029 Reset asserted mid-operation (including in HOLD) aborts any pending grant; no out_load or req_ack pulse appears after reset asserts.
REQ-030 The first grant can occur in the decision cycle at the first rising edge after reset deasserts.

Structure
REQ-031 A shared package holds NPORT, AW, the port index type (3 bits), and the FSM state enum {IDLE, HOLD}.
REQ-032 One sub-module, rr_arb, holds the per-output FSM and the round-robin pointer; it is instantiated NPORT times by generate.
REQ-033 Request-matrix decode and drop logic live in the top level of router_sched.

Verification
REQ-034 Single request: after reset, inputs 0 and 5 request output 2 with out_rdy[2]=1; grant goes to 0 first, then to 5 two cycles later, with ptr[2]=5.
REQ-035 Fairness: inputs 0, 3 and 7 continuously re-request output 4 with out_rdy[4]=1; grants follow 0,3,7,0,3,7, each out_load[4] two cycles apart.
REQ-036 Backpressure: input 1 requests output 6 with out_rdy[6]=0 for 10 cycles; no out_load[6] occurs, and the grant arrives one cycle after out_rdy[6] rises.
REQ-037 Parallel grants: inputs 0..7 request outputs 7..0 with all out_rdy=1; all 8 out_load and all 8 req_ack pulse in the same cycle.
REQ-038 Drop: inputs 2 and 4 present addr=9 simultaneously; err_drop pulses on two consecutive cycles (input 2 first), drop_cnt reaches 2, and no out_load occurs.
REQ-039 Reset in HOLD: assert reset in the cycle after a grant decision; no out_load appears, and after release ptr is back at 7.

Source files
------------

// File: rtl/router_sched_pkg.sv
// router_sched_pkg: port count, address width, port index type and the
// per-output grant FSM states shared by the router scheduler.
package router_sched_pkg;
   localparam int NPORT = 8;
   localparam int AW    = 4;
   typedef logic [2:0] port_t;
   typedef enum logic {IDLE, HOLD} state_e;
endpackage

// File: rtl/router_sched_rr_arb.sv
// rr_arb: one output port's IDLE/HOLD grant FSM with its round-robin pointer.
// Grants are registered; HOLD masks the winner's still-high request for one cycle.
module rr_arb
   import router_sched_pkg::*;
#(
   parameter int N = router_sched_pkg::NPORT
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [N-1:0] req_i,
   input  logic         rdy_i,
   output logic         load_o,
   output port_t        sel_o,
   output logic [N-1:0] gnt_o
);
   state_e state_q, state_d;
   port_t  ptr_q, ptr_d, sel_d, win, idx;
   logic   found, load_d;

   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 1; k <= N; k++) begin
         idx = port_t'((int'(ptr_q) + k) % N);
         if (!found && req_i[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      load_d  = state_q == IDLE && rdy_i && found;
      state_d = load_d ? HOLD : IDLE;
      ptr_d   = load_d ? win : ptr_q;
      sel_d   = load_d ? win : '0;
   end

   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         state_q <= IDLE;
         ptr_q   <= port_t'(N - 1);
         load_o  <= 1'b0;
         sel_o   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         load_o  <= load_d;
         sel_o   <= sel_d;
      end

   assign gnt_o = load_o ? {{(N-1){1'b0}}, 1'b1} << sel_o : '0;
endmodule

// File: rtl/router_sched.sv
// router_sched: decodes per-input destinations into per-output request vectors,
// runs one rr_arb per output, and discards out-of-range requests one per cycle.
module router_sched
   import router_sched_pkg::*;
#(
   parameter int NPORT = router_sched_pkg::NPORT,
   parameter int AW    = router_sched_pkg::AW
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NPORT-1:0]    req_vld_i,
   input  logic [NPORT*AW-1:0] req_addr_i,
   input  logic [NPORT-1:0]    out_rdy_i,
   output logic [NPORT-1:0]    req_ack_o,
   output logic [NPORT-1:0]    out_load_o,
   output logic [NPORT*3-1:0]  out_sel_o,
   output logic                err_drop_o,
   output logic [15:0]         drop_cnt_o
);
   logic [NPORT-1:0] req_mat [NPORT];
   logic [NPORT-1:0] gnt [NPORT];
   logic [NPORT-1:0] oor, drop_ack_q, drop_ack_d;
   logic [15:0]      drop_cnt_q, drop_cnt_d;

   always_comb begin
      oor = '0;
      for (int o = 0; o < NPORT; o++) req_mat[o] = '0;
      for (int i = 0; i < NPORT; i++) begin
         oor[i] = req_vld_i[i] && int'(req_addr_i[i*AW +: AW]) >= NPORT;
         for (int o = 0; o < NPORT; o++)
            req_mat[o][i] = req_vld_i[i] && int'(req_addr_i[i*AW +: AW]) == o;
      end
   end

   // A request being acked for a drop is still high this cycle; skip it.
   always_comb begin
      drop_ack_d = '0;
      for (int i = NPORT - 1; i >= 0; i--)
         if (oor[i] && !drop_ack_q[i]) begin
            drop_ack_d    = '0;
            drop_ack_d[i] = 1'b1;
         end
      drop_cnt_d = (|drop_ack_d && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
   end

   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         drop_ack_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         drop_ack_q <= drop_ack_d;
         drop_cnt_q <= drop_cnt_d;
      end

   for (genvar g = 0; g < NPORT; g++) begin : g_arb
      rr_arb #(.N(NPORT)) u_arb (
         .clk_i  (clk_i),
         .rst_i  (rst_i),
         .req_i  (req_mat[g]),
         .rdy_i  (out_rdy_i[g]),
         .load_o (out_load_o[g]),
         .sel_o  (out_sel_o[g*3 +: 3]),
         .gnt_o  (gnt[g])
      );
   end

   always_comb begin
      req_ack_o = drop_ack_q;
      for (int o = 0; o < NPORT; o++) req_ack_o = req_ack_o | gnt[o];
   end

   assign err_drop_o = |drop_ack_q;
   assign drop_cnt_o = drop_cnt_q;
endmodule

// File: tb/tb_router_sched.sv
// tb_router_sched: single-decision vector table, directed multi-cycle sequences,
// counter saturation, and a randomized run against a behavioural scheduler model.
module tb_router_sched;
   localparam int N = 8;

   logic         clk = 1'b0, rst = 1'b1;
   logic [N-1:0] vld = '0, rdy = '0, ack, load;
   logic [N*4-1:0] addr = '0;
   logic [N*3-1:0] sel;
   logic         err;
   logic [15:0]  cnt;
   int vectors = 0, miscompares = 0;

   router_sched dut (
      .clk_i(clk), .rst_i(rst), .req_vld_i(vld), .req_addr_i(addr), .out_rdy_i(rdy),
      .req_ack_o(ack), .out_load_o(load), .out_sel_o(sel), .err_drop_o(err), .drop_cnt_o(cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] vld;
      logic [31:0]  addr;
      logic [N-1:0] rdy;
      logic [N-1:0] ack;
      logic [N-1:0] load;
      logic [23:0]  sel;
      logic         err;
      logic [15:0]  cnt;
   } vec_t;
   vec_t tbl [6];

   logic [N-1:0] ack_seen = '0, sticky = '0, any_load, eack, eload;
   logic [23:0]  esel, selmask;
   logic         eerr;
   int           mptr [N];
   bit           mhold [N];
   logic [N-1:0] mdrop;
   int           mcnt;
   int           order [6] = '{0, 3, 7, 0, 3, 7};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Requesters drop vld on the edge that ends their ack cycle, unless sticky.
   task automatic step();
      tick();
      vld      = vld & ~(ack_seen & ~sticky);
      ack_seen = ack;
   endtask

   task automatic do_reset();
      rst = 1'b1; vld = '0; addr = '0; rdy = '0; ack_seen = '0; sticky = '0;
      tick();
      chk("rst_ack", 32'(ack), 32'h0);
      chk("rst_load", 32'(load), 32'h0);
      chk("rst_sel", 32'(sel), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_cnt", 32'(cnt), 32'h0);
      tick();
      rst = 1'b0;
   endtask

   // Reference: per output, a busy cycle after each grant and a round-robin
   // search from the last winner; drops go to the lowest out-of-range input
   // not already being acked for a drop.
   task automatic model(output logic [N-1:0] a, output logic [N-1:0] l,
                        output logic [23:0] s, output logic e);
      int i;
      logic [N-1:0] nd;
      a = '0; l = '0; s = '0; e = 1'b0; nd = '0;
      for (int o = 0; o < N; o++) begin
         if (mhold[o]) mhold[o] = 1'b0;
         else if (rdy[o])
            for (int k = 1; k <= N; k++) begin
               i = (mptr[o] + k) % N;
               if (!l[o] && vld[i] && int'(addr[i*4 +: 4]) == o) begin
                  l[o] = 1'b1;
                  s[o*3 +: 3] = 3'(i);
                  a[i] = 1'b1;
                  mptr[o] = i;
                  mhold[o] = 1'b1;
               end
            end
      end
      for (int j = 0; j < N; j++)
         if (nd == '0 && vld[j] && int'(addr[j*4 +: 4]) >= N && !mdrop[j]) begin
            nd[j] = 1'b1;
            a[j] = 1'b1;
            e = 1'b1;
            if (mcnt < 65535) mcnt++;
         end
      mdrop = nd;
   endtask

   initial begin
      tbl[0] = '{8'h21, 32'h00200002, 8'hFF, 8'h01, 8'h04, 24'h000000, 1'b0, 16'd0};
      tbl[1] = '{8'hFF, 32'h01234567, 8'hFF, 8'hFF, 8'hFF, 24'h053977, 1'b0, 16'd0};
      tbl[2] = '{8'hFF, 32'h01234567, 8'h00, 8'h00, 8'h00, 24'h000000, 1'b0, 16'd0};
      tbl[3] = '{8'h14, 32'h00090900, 8'hFF, 8'h04, 8'h00, 24'h000000, 1'b1, 16'd1};
      tbl[4] = '{8'h4A, 32'h05005050, 8'h20, 8'h02, 8'h20, 24'h008000, 1'b0, 16'd0};
      tbl[5] = '{8'h87, 32'h600003F3, 8'h08, 8'h03, 8'h08, 24'h000000, 1'b1, 16'd1};

      for (int v = 0; v < 6; v++) begin
         do_reset();
         vld = tbl[v].vld; addr = tbl[v].addr; rdy = tbl[v].rdy;
         tick();
         chk($sformatf("vec%0d_ack", v), 32'(ack), 32'(tbl[v].ack));
         chk($sformatf("vec%0d_load", v), 32'(load), 32'(tbl[v].load));
         chk($sformatf("vec%0d_sel", v), 32'(sel), 32'(tbl[v].sel));
         chk($sformatf("vec%0d_err", v), 32'(err), 32'(tbl[v].err));
         chk($sformatf("vec%0d_cnt", v), 32'(cnt), 32'(tbl[v].cnt));
      end

      // Two requesters on output 2, then pointer check via the next contest.
      do_reset();
      vld = 8'h21; addr = 32'h00200002; rdy = 8'hFF;
      step();
      chk("rr_first_load", 32'(load), 32'h04);
      chk("rr_first_sel", 32'(sel[8:6]), 32'd0);
      chk("rr_first_ack", 32'(ack), 32'h01);
      step();
      chk("rr_hold_load", 32'(load), 32'h0);
      chk("rr_hold_ack", 32'(ack), 32'h0);
      step();
      chk("rr_second_load", 32'(load), 32'h04);
      chk("rr_second_sel", 32'(sel[8:6]), 32'd5);
      chk("rr_second_ack", 32'(ack), 32'h20);
      vld = vld | 8'h41; addr = 32'h02200002;
      step();
      chk("rr_gap_load", 32'(load), 32'h0);
      step();
      chk("rr_ptr_sel", 32'(sel[8:6]), 32'd6);
      chk("rr_ptr_ack", 32'(ack), 32'h40);

      // Fairness among inputs 0, 3, 7 that always hold a fresh payload.
      do_reset();
      vld = 8'h89; sticky = 8'h89; addr = 32'h40004004; rdy = 8'hFF;
      for (int c = 0; c < 12; c++) begin
         step();
         if (c % 2 == 0) begin
            chk($sformatf("fair%0d_load", c), 32'(load), 32'h10);
            chk($sformatf("fair%0d_sel", c), 32'(sel[14:12]), 32'(order[c/2]));
         end else chk($sformatf("fair%0d_idle", c), 32'(load), 32'h0);
      end

      // Backpressure on output 6.
      do_reset();
      vld = 8'h02; addr = 32'h00000060; rdy = 8'h00;
      any_load = '0;
      for (int c = 0; c < 10; c++) begin
         step();
         any_load = any_load | load;
      end
      chk("bp_noload", 32'(any_load), 32'h0);
      rdy = 8'h40;
      step();
      chk("bp_load", 32'(load), 32'h40);
      chk("bp_sel", 32'(sel[20:18]), 32'd1);
      chk("bp_ack", 32'(ack), 32'h02);

      // Two simultaneous out-of-range requests.
      do_reset();
      vld = 8'h14; addr = 32'h00090900; rdy = 8'hFF;
      step();
      chk("drop1_ack", 32'(ack), 32'h04);
      chk("drop1_err", 32'(err), 32'h1);
      chk("drop1_cnt", 32'(cnt), 32'd1);
      chk("drop1_load", 32'(load), 32'h0);
      step();
      chk("drop2_ack", 32'(ack), 32'h10);
      chk("drop2_err", 32'(err), 32'h1);
      chk("drop2_cnt", 32'(cnt), 32'd2);
      chk("drop2_load", 32'(load), 32'h0);
      step();
      chk("drop3_ack", 32'(ack), 32'h0);
      chk("drop3_err", 32'(err), 32'h0);
      chk("drop3_cnt", 32'(cnt), 32'd2);

      // Reset while a grant is in HOLD, then pointer must be back at 7.
      do_reset();
      vld = 8'h08; addr = 32'h00001000; rdy = 8'hFF;
      tick();
      rst = 1'b1;
      #1;
      chk("rsthold_load", 32'(load), 32'h0);
      chk("rsthold_ack", 32'(ack), 32'h0);
      tick();
      chk("rsthold_load2", 32'(load), 32'h0);
      rst = 1'b0; vld = 8'h28; addr = 32'h00101000;
      tick();
      chk("rsthold_sel", 32'(sel[5:3]), 32'd3);
      chk("rsthold_ack2", 32'(ack), 32'h08);
      chk("rsthold_ld", 32'(load), 32'h02);

      // Drop counter saturation with two inputs alternating drops every cycle.
      do_reset();
      vld = 8'h03; sticky = 8'h03; addr = 32'h000000FF; rdy = 8'h00;
      for (int c = 0; c < 70000 && cnt != 16'hFFFF; c++) step();
      chk("sat_reach", 32'(cnt), 32'hFFFF);
      for (int c = 0; c < 3; c++) begin
         step();
         chk($sformatf("sat_hold%0d", c), 32'(cnt), 32'hFFFF);
         chk($sformatf("sat_err%0d", c), 32'(err), 32'h1);
      end

      // Randomized traffic against the reference model.
      do_reset();
      for (int o = 0; o < N; o++) begin
         mptr[o] = N - 1;
         mhold[o] = 1'b0;
      end
      mdrop = '0; mcnt = 0;
      for (int c = 0; c < 400; c++) begin
         model(eack, eload, esel, eerr);
         step();
         selmask = '0;
         for (int o = 0; o < N; o++) selmask[o*3 +: 3] = {3{eload[o]}};
         chk("rnd_ack", 32'(ack), 32'(eack));
         chk("rnd_load", 32'(load), 32'(eload));
         chk("rnd_sel", 32'(sel & selmask), 32'(esel));
         chk("rnd_err", 32'(err), 32'(eerr));
         chk("rnd_cnt", 32'(cnt), 32'(mcnt));
         for (int i = 0; i < N; i++)
            if (!vld[i] && $urandom_range(0, 2) == 0) begin
               vld[i] = 1'b1;
               addr[i*4 +: 4] = 4'($urandom_range(0, 9));
            end
         rdy = N'($urandom() | $urandom());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
